// File: rtl/led_pattern_decoder.sv
// Receive-side monitor for a bouncing one-hot LED bus: decodes position and direction,
// tracks the 0..7..0 bounce sequence, counts sweeps and latches the first error cause.
module led_pattern_decoder #(
    parameter int SWEEP_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         led_in,
    input  logic               led_valid,
    input  logic               err_clr,
    output logic [2:0]         pos,
    output logic               pos_valid,
    output logic               dir,
    output logic               locked,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               err,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    localparam logic [1:0]         CODE_NONE   = 2'd0;
    localparam logic [1:0]         CODE_ONEHOT = 2'd1;
    localparam logic [1:0]         CODE_SEQ    = 2'd2;
    localparam logic [SWEEP_W-1:0] SWEEP_MAX   = {SWEEP_W{1'b1}};
    localparam logic [SWEEP_W-1:0] SWEEP_ONE   = {{(SWEEP_W-1){1'b0}}, 1'b1};

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_to_pos(input logic [7:0] v);
        logic [2:0] p;
        p = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                p = 3'(i);
            end
        end
        return p;
    endfunction

    state_t                state_r;
    logic [2:0]            pos_r;
    logic                  pos_valid_r;
    logic                  dir_r;
    logic                  locked_r;
    logic [SWEEP_W-1:0]    sweep_count_r;
    logic                  err_r;
    logic [1:0]            err_code_r;

    logic                  onehot_s;
    logic [2:0]            in_pos_s;
    logic [2:0]            exp_pos_s;
    logic                  exp_dir_s;
    logic                  up_match_s;
    logic                  dn_match_s;
    logic                  err_det_s;
    logic [1:0]            err_cause_s;

    // Decode the sample, predict the next legal position and classify any error.
    always_comb begin
        onehot_s    = is_onehot(led_in);
        in_pos_s    = onehot_to_pos(led_in);
        // Compare in 4 bits so 7->0 and 0->7 never look like neighbours during acquisition.
        up_match_s  = ({1'b0, in_pos_s} == ({1'b0, pos_r} + 4'd1));
        dn_match_s  = (({1'b0, in_pos_s} + 4'd1) == {1'b0, pos_r});
        exp_pos_s   = 3'd0;
        exp_dir_s   = 1'b0;
        if (dir_r == 1'b0) begin
            if (pos_r == 3'd7) begin
                exp_pos_s = 3'd6;
                exp_dir_s = 1'b1;
            end else begin
                exp_pos_s = pos_r + 3'd1;
                exp_dir_s = 1'b0;
            end
        end else begin
            if (pos_r == 3'd0) begin
                exp_pos_s = 3'd1;
                exp_dir_s = 1'b0;
            end else begin
                exp_pos_s = pos_r - 3'd1;
                exp_dir_s = 1'b1;
            end
        end
        err_det_s   = 1'b0;
        err_cause_s = CODE_NONE;
        if (led_valid && !onehot_s) begin
            err_det_s   = 1'b1;
            err_cause_s = CODE_ONEHOT;
        end else if (led_valid && (state_r == ST_LOCKED) && (in_pos_s != exp_pos_s)) begin
            err_det_s   = 1'b1;
            err_cause_s = CODE_SEQ;
        end else begin
            err_det_s   = 1'b0;
            err_cause_s = CODE_NONE;
        end
    end

    // Tracking FSM with registered outputs and sticky first-error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_UNLOCKED;
            pos_r         <= 3'd0;
            pos_valid_r   <= 1'b0;
            dir_r         <= 1'b0;
            locked_r      <= 1'b0;
            sweep_count_r <= {SWEEP_W{1'b0}};
            err_r         <= 1'b0;
            err_code_r    <= CODE_NONE;
        end else begin
            pos_valid_r <= 1'b0;
            if (led_valid) begin
                if (!onehot_s) begin
                    state_r  <= ST_UNLOCKED;
                    locked_r <= 1'b0;
                end else begin
                    pos_valid_r <= 1'b1;
                    pos_r       <= in_pos_s;
                    case (state_r)
                        ST_UNLOCKED: begin
                            state_r <= ST_ACQUIRE;
                        end
                        ST_ACQUIRE: begin
                            if (up_match_s) begin
                                dir_r    <= 1'b0;
                                state_r  <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end else if (dn_match_s) begin
                                dir_r    <= 1'b1;
                                state_r  <= ST_LOCKED;
                                locked_r <= 1'b1;
                            end else begin
                                state_r <= ST_ACQUIRE;
                            end
                        end
                        ST_LOCKED: begin
                            if (in_pos_s == exp_pos_s) begin
                                dir_r <= exp_dir_s;
                                if (((in_pos_s == 3'd7) || (in_pos_s == 3'd0)) &&
                                    (sweep_count_r != SWEEP_MAX)) begin
                                    sweep_count_r <= sweep_count_r + SWEEP_ONE;
                                end
                            end else begin
                                state_r  <= ST_ACQUIRE;
                                locked_r <= 1'b0;
                            end
                        end
                        default: begin
                            state_r  <= ST_UNLOCKED;
                            locked_r <= 1'b0;
                        end
                    endcase
                end
            end
            // A fresh error beats a simultaneous clear and overwrites the cause.
            if (err_det_s) begin
                err_r <= 1'b1;
                if (!err_r || err_clr) begin
                    err_code_r <= err_cause_s;
                end
            end else if (err_clr) begin
                err_r      <= 1'b0;
                err_code_r <= CODE_NONE;
            end
        end
    end

    assign pos         = pos_r;
    assign pos_valid   = pos_valid_r;
    assign dir         = dir_r;
    assign locked      = locked_r;
    assign sweep_count = sweep_count_r;
    assign err         = err_r;
    assign err_code    = err_code_r;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed self-checking bench for led_pattern_decoder; a second instance with
// SWEEP_W = 2 shares the stimulus to exercise sweep counter saturation.
module tb_led_pattern_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  led_in = 8'h00;
    logic        led_valid = 1'b0;
    logic        err_clr = 1'b0;

    logic [2:0]  pos, pos2;
    logic        pos_valid, pos_valid2;
    logic        dir, dir2;
    logic        locked, locked2;
    logic [15:0] sweep_count;
    logic [1:0]  sweep_count2;
    logic        err, err2;
    logic [1:0]  err_code, err_code2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_decoder #(.SWEEP_W(16)) u_dut (
        .clk(clk), .rst(rst), .led_in(led_in), .led_valid(led_valid), .err_clr(err_clr),
        .pos(pos), .pos_valid(pos_valid), .dir(dir), .locked(locked),
        .sweep_count(sweep_count), .err(err), .err_code(err_code)
    );

    led_pattern_decoder #(.SWEEP_W(2)) u_sat (
        .clk(clk), .rst(rst), .led_in(led_in), .led_valid(led_valid), .err_clr(err_clr),
        .pos(pos2), .pos_valid(pos_valid2), .dir(dir2), .locked(locked2),
        .sweep_count(sweep_count2), .err(err2), .err_code(err_code2)
    );

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic [7:0] v, input logic vld, input logic clr, input logic r);
        @(negedge clk);
        led_in = v; led_valid = vld; err_clr = clr; rst = r;
        @(posedge clk);
        #1;
        led_valid = 1'b0; err_clr = 1'b0; rst = 1'b0;
    endtask

    function automatic logic [7:0] lamp(input int p);
        logic [7:0] one;
        one = 8'h01;
        return one << p;
    endfunction

    task automatic test_reset();
        step(8'h01, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({pos, pos_valid, dir, locked, sweep_count, err, err_code} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pos, pos_valid, dir, locked, sweep_count, err, err_code});
        end
    endtask

    task automatic test_dense();
        int p;
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            p = (i < 8) ? i : 14 - i;
            step(lamp(p), 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (pos !== 3'(p)) begin n_fail++; $display("FAIL dense_pos[%0d]: got %0d expected %0d", i, pos, p); end
            n_checks++;
            if (locked !== (i >= 1)) begin n_fail++; $display("FAIL dense_locked[%0d]: got %0b expected %0b", i, locked, (i >= 1)); end
            n_checks++;
            if (dir !== (i >= 8)) begin n_fail++; $display("FAIL dense_dir[%0d]: got %0b expected %0b", i, dir, (i >= 8)); end
            n_checks++;
            if (sweep_count !== 16'((i < 7) ? 0 : (i < 14) ? 1 : 2)) begin
                n_fail++; $display("FAIL dense_sweep[%0d]: got %0d", i, sweep_count);
            end
            n_checks++;
            if ({err, pos_valid} !== 2'b01) begin n_fail++; $display("FAIL dense_err_pv[%0d]: got %b expected 01", i, {err, pos_valid}); end
        end
    endtask

    task automatic test_seq_break();
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(lamp(i), 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({locked, dir, pos} !== 5'b10_011) begin n_fail++; $display("FAIL break_pre: got %b expected 10011", {locked, dir, pos}); end
        step(8'h40, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({err, err_code, locked, pos, pos_valid} !== 8'b1_10_0_110_1) begin
            n_fail++; $display("FAIL break_err: got %b expected 11001101", {err, err_code, locked, pos, pos_valid});
        end
        step(8'h80, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({locked, dir, pos, sweep_count} !== {2'b10, 3'd7, 16'd0}) begin
            n_fail++; $display("FAIL break_relock: got locked=%0b dir=%0b pos=%0d sweep=%0d expected 1 0 7 0", locked, dir, pos, sweep_count);
        end
    endtask

    task automatic test_not_onehot();
        step(8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({err, err_code} !== 3'b000) begin n_fail++; $display("FAIL noh_clear: got %b expected 000", {err, err_code}); end
        step(8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({err, err_code, locked, pos_valid, pos, dir} !== 9'b1_01_0_0_111_0) begin
            n_fail++; $display("FAIL noh_zero: got %b expected 101001110", {err, err_code, locked, pos_valid, pos, dir});
        end
        step(8'h05, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({err, err_code, pos_valid, pos} !== 7'b1_01_0_111) begin
            n_fail++; $display("FAIL noh_hold: got %b expected 1010111", {err, err_code, pos_valid, pos});
        end
        // From UNLOCKED two samples are needed before lock returns.
        step(8'h40, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({locked, pos} !== 4'b0_110) begin n_fail++; $display("FAIL noh_unlocked: got %b expected 0110", {locked, pos}); end
        step(8'h20, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({locked, dir, pos} !== 5'b1_1_101) begin n_fail++; $display("FAIL noh_relock: got %b expected 11101", {locked, dir, pos}); end
    endtask

    task automatic test_gapped();
        int p;
        int pulses;
        pulses = 0;
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            p = (i < 8) ? i : 14 - i;
            step(lamp(p), 1'b1, 1'b0, 1'b0);
            if (pos_valid === 1'b1) pulses++;
            n_checks++;
            if ({pos, dir, sweep_count} !== {3'(p), (i >= 8), 16'((i < 7) ? 0 : (i < 14) ? 1 : 2)}) begin
                n_fail++; $display("FAIL gap_state[%0d]: got pos=%0d dir=%0b sweep=%0d", i, pos, dir, sweep_count);
            end
            for (int g = 0; g < 2; g++) begin
                step(8'hFF, 1'b0, 1'b0, 1'b0);
                if (pos_valid === 1'b1) pulses++;
                n_checks++;
                if ({pos, pos_valid, err} !== {3'(p), 2'b00}) begin
                    n_fail++; $display("FAIL gap_idle[%0d]: got pos=%0d pv=%0b err=%0b", i, pos, pos_valid, err);
                end
            end
        end
        n_checks++;
        if (pulses !== 15) begin n_fail++; $display("FAIL gap_pulses: got %0d expected 15", pulses); end
    endtask

    task automatic test_err_clr();
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({err, err_code} !== 3'b101) begin n_fail++; $display("FAIL clr_set: got %b expected 101", {err, err_code}); end
        step(8'h00, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({err, err_code} !== 3'b000) begin n_fail++; $display("FAIL clr_alone: got %b expected 000", {err, err_code}); end
        step(8'h03, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({err, err_code} !== 3'b101) begin n_fail++; $display("FAIL clr_vs_onehot: got %b expected 101", {err, err_code}); end
        step(8'h01, 1'b1, 1'b0, 1'b0);
        step(8'h02, 1'b1, 1'b0, 1'b0);
        step(8'h10, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({err, err_code, locked} !== 4'b1_10_0) begin n_fail++; $display("FAIL clr_vs_seq: got %b expected 1100", {err, err_code, locked}); end
    endtask

    task automatic test_saturation();
        int p, d, k;
        p = 0; d = 0; k = 0;
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 43; i++) begin
            if (i > 0) begin
                if (d == 0) begin
                    if (p == 7) begin p = 6; d = 1; end else p = p + 1;
                end else begin
                    if (p == 0) begin p = 1; d = 0; end else p = p - 1;
                end
            end
            step(lamp(p), 1'b1, 1'b0, 1'b0);
            if (i > 0 && (p == 7 || p == 0)) k++;
            n_checks++;
            if (sweep_count2 !== 2'((k > 3) ? 3 : k)) begin
                n_fail++; $display("FAIL sat_narrow[%0d]: got %0d expected %0d", i, sweep_count2, (k > 3) ? 3 : k);
            end
        end
        n_checks++;
        if ({sweep_count, sweep_count2} !== {16'd6, 2'd3}) begin
            n_fail++; $display("FAIL sat_final: got wide=%0d narrow=%0d expected 6 3", sweep_count, sweep_count2);
        end
    endtask

    task automatic test_mid_reset();
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(lamp(i), 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({locked, err, sweep_count} !== {2'b11, 16'd1}) begin
            n_fail++; $display("FAIL midrst_pre: got locked=%0b err=%0b sweep=%0d", locked, err, sweep_count);
        end
        step(8'h40, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({pos, pos_valid, dir, locked, sweep_count, err, err_code} !== 25'd0) begin
            n_fail++; $display("FAIL midrst_wide: got %h expected 0", {pos, pos_valid, dir, locked, sweep_count, err, err_code});
        end
        n_checks++;
        if ({pos2, pos_valid2, dir2, locked2, sweep_count2, err2, err_code2} !== 11'd0) begin
            n_fail++; $display("FAIL midrst_narrow: got %h expected 0", {pos2, pos_valid2, dir2, locked2, sweep_count2, err2, err_code2});
        end
    endtask

    initial begin
        test_reset();
        test_dense();
        test_seq_break();
        test_not_onehot();
        test_gapped();
        test_err_clr();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
